// File: rtl/adc_multi_capture.sv
// adc_multi_capture
// Serial-ADC capture engine for a MAX1379-class converter. The block generates
// CNVST/SCLK and shifts NUM_CH data lines in parallel, MSB first. It supports
// single-shot and continuous modes and optional 2^AVG_LOG2 averaging.
// Every register runs on CLOCK_50MHz. SCLK is only a registered output, and all
// conversion activity is qualified by the one-cycle "rise" event.

module adc_multi_capture #(
    parameter int CLK_DIV    = 4,
    parameter int NUM_CH     = 2,
    parameter int ADC_BITS   = 12,
    parameter int OUT_BITS   = 8,
    parameter int LAT_CYCLES = 3,
    parameter int AVG_LOG2   = 0
) (
    input  logic                       CLOCK_50MHz,
    input  logic                       RESET_n,
    input  logic                       START,
    input  logic                       CONT,
    input  logic [NUM_CH-1:0]          ADC_OUT,
    output logic                       ADC_CNVST,
    output logic                       ADC_SCLK,
    output logic                       ADC_CS_N,
    output logic                       ADC_REFSEL,
    output logic                       ADC_SD,
    output logic                       ADC_UB,
    output logic                       ADC_SEL,
    output logic                       BUSY,
    output logic                       DATA_VALID,
    output logic [NUM_CH*OUT_BITS-1:0] DATA_OUT,
    output logic                       OVERRUN
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (LAT_CYCLES > ADC_BITS) ? LAT_CYCLES : ADC_BITS;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int GRP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(ADC_BITS - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The averaged result is the top OUT_BITS of the accumulator, which is a
    // truncating divide by 2^AVG_LOG2 followed by dropping the low ADC bits.
    function automatic logic [OUT_BITS-1:0] scale_out(input logic [ACC_W-1:0] acc);
        return acc[ACC_W-1 -: OUT_BITS];
    endfunction

    logic [DIV_W-1:0]                 div_cnt_r;
    logic                             sclk_r;
    logic                             tc_s;
    logic                             rise_s;

    state_t                           state_r;
    state_t                           state_s;
    logic [CNT_W-1:0]                 cnt_r;
    logic                             conv_start_s;
    logic                             cnt_clr_s;
    logic                             cnt_inc_s;
    logic                             shift_en_s;
    logic                             done_s;
    logic                             go_s;

    logic                             pending_r;
    logic                             overrun_r;
    logic                             start_req_s;
    logic                             cnvst_r;
    logic                             busy_r;
    logic                             data_valid_r;

    logic [NUM_CH-1:0][ADC_BITS-1:0]  shift_r;
    logic [NUM_CH-1:0][ACC_W-1:0]     acc_r;
    logic [NUM_CH-1:0][ACC_W-1:0]     acc_sum_s;
    logic [GRP_W-1:0]                 grp_cnt_r;
    logic                             grp_last_s;
    logic [NUM_CH*OUT_BITS-1:0]       data_out_r;
    logic [NUM_CH*OUT_BITS-1:0]       data_out_s;

    assign tc_s        = (div_cnt_r == DIV_LAST);
    assign rise_s      = tc_s & ~sclk_r;
    assign start_req_s = START & ~CONT;
    assign grp_last_s  = (grp_cnt_r == GRP_LAST);
    assign go_s        = CONT | pending_r | (grp_cnt_r != {GRP_W{1'b0}});

    // SCLK divider: toggle SCLK each time the counter reaches its terminal count.
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sclk_r    <= 1'b0;
        end else if (tc_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sclk_r    <= ~sclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and datapath strobes. Everything advances only on rise events.
    always_comb begin
        state_s      = state_r;
        conv_start_s = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        shift_en_s   = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s && go_s) begin
                    conv_start_s = 1'b1;
                    cnt_clr_s    = 1'b1;
                    state_s      = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (rise_s) begin
                    if (cnt_r == LAT_LAST) begin
                        cnt_clr_s = 1'b1;
                        state_s   = ST_SHIFT;
                    end else begin
                        cnt_inc_s = 1'b1;
                        state_s   = ST_WAIT;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    shift_en_s = 1'b1;
                    if (cnt_r == BIT_LAST) begin
                        cnt_clr_s = 1'b1;
                        state_s   = ST_DONE;
                    end else begin
                        cnt_inc_s = 1'b1;
                        state_s   = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (rise_s) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Rise counter shared by the latency wait and the data shift phases.
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Per-channel shift registers. Each one takes ADC_OUT[k] MSB first on shift rises.
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            shift_r <= '0;
        end else if (shift_en_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shift_r[k] <= {shift_r[k][ADC_BITS-2:0], ADC_OUT[k]};
            end
        end else begin
            shift_r <= shift_r;
        end
    end

    // Running sums that include the just-finished sample, and the scaled result fields.
    always_comb begin
        acc_sum_s  = '0;
        data_out_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_sum_s[k] = acc_r[k] + ACC_W'(shift_r[k]);
            data_out_s[k*OUT_BITS +: OUT_BITS] = scale_out(acc_sum_s[k]);
        end
    end

    // Accumulate each conversion. Publish the result and strobe DATA_VALID when the group closes.
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            acc_r        <= '0;
            grp_cnt_r    <= {GRP_W{1'b0}};
            data_out_r   <= {(NUM_CH*OUT_BITS){1'b0}};
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= done_s & grp_last_s;
            if (done_s) begin
                if (grp_last_s) begin
                    acc_r      <= '0;
                    grp_cnt_r  <= {GRP_W{1'b0}};
                    data_out_r <= data_out_s;
                end else begin
                    acc_r     <= acc_sum_s;
                    grp_cnt_r <= grp_cnt_r + GRP_W'(1);
                end
            end
        end
    end

    // CNVST and BUSY. BUSY stays up across an unfinished averaging group.
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            cnvst_r <= 1'b1;
            busy_r  <= 1'b0;
        end else if (conv_start_s) begin
            cnvst_r <= 1'b0;
            busy_r  <= 1'b1;
        end else if (done_s) begin
            cnvst_r <= 1'b1;
            busy_r  <= ~grp_last_s;
        end else begin
            cnvst_r <= cnvst_r;
            busy_r  <= busy_r;
        end
    end

    // One-deep request holder. A second request while one is held sets the sticky overrun flag.
    always_ff @(posedge CLOCK_50MHz) begin
        if (!RESET_n) begin
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (start_req_s) begin
                pending_r <= 1'b1;
            end else if (conv_start_s) begin
                pending_r <= 1'b0;
            end
            if (start_req_s && pending_r) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign ADC_CNVST  = cnvst_r;
    assign ADC_SCLK   = sclk_r;
    assign ADC_CS_N   = 1'b0;
    assign ADC_REFSEL = 1'b1;
    assign ADC_SD     = 1'b0;
    assign ADC_UB     = 1'b0;
    assign ADC_SEL    = 1'b0;
    assign BUSY       = busy_r;
    assign DATA_VALID = data_valid_r;
    assign DATA_OUT   = data_out_r;
    assign OVERRUN    = overrun_r;

endmodule

// File: tb/tb_adc_multi_capture.sv
// Bench for adc_multi_capture. It uses two instances: one with default
// parameters and one with AVG_LOG2=2. A converter model answers each instance.
// Every check compares against values derived from the sample words by arithmetic.

module tb_adc_multi_capture;

    localparam int CLK_DIV  = 4;
    localparam int ADC_BITS = 12;
    localparam int LAT      = 3;
    localparam int PERIOD   = (LAT + ADC_BITS + 2) * 2 * CLK_DIV;

    logic        CLOCK_50MHz = 1'b0;
    logic        RESET_n = 1'b0;
    logic        START = 1'b0, CONT = 1'b0, start_a = 1'b0, cont_a = 1'b0;
    logic [1:0]  adc_out0 = 2'b00, adc_out1 = 2'b00;

    logic        cnvst0, sclk0, cs_n0, refsel0, sd0, ub0, sel0, busy0, valid0, ovr0;
    logic [15:0] dout0;
    logic        cnvst1, sclk1, cs_n1, refsel1, sd1, ub1, sel1, busy1, valid1, ovr1;
    logic [15:0] dout1;

    int n_tests = 0;
    int n_fail  = 0;

    // sample words are ch1*4096 + ch0; one word is consumed per conversion
    logic [23:0] sq0[$];
    logic [23:0] sq1[$];
    logic [23:0] cur0 = 24'd0, cur1 = 24'd0;
    logic        ps0 = 1'b0, pc0 = 1'b1, ps1 = 1'b0, pc1 = 1'b1;
    int          f0 = 0, f1 = 0;

    adc_multi_capture dut (
        .CLOCK_50MHz(CLOCK_50MHz), .RESET_n(RESET_n), .START(START), .CONT(CONT),
        .ADC_OUT(adc_out0), .ADC_CNVST(cnvst0), .ADC_SCLK(sclk0), .ADC_CS_N(cs_n0),
        .ADC_REFSEL(refsel0), .ADC_SD(sd0), .ADC_UB(ub0), .ADC_SEL(sel0),
        .BUSY(busy0), .DATA_VALID(valid0), .DATA_OUT(dout0), .OVERRUN(ovr0)
    );

    adc_multi_capture #(.AVG_LOG2(2)) dut_a (
        .CLOCK_50MHz(CLOCK_50MHz), .RESET_n(RESET_n), .START(start_a), .CONT(cont_a),
        .ADC_OUT(adc_out1), .ADC_CNVST(cnvst1), .ADC_SCLK(sclk1), .ADC_CS_N(cs_n1),
        .ADC_REFSEL(refsel1), .ADC_SD(sd1), .ADC_UB(ub1), .ADC_SEL(sel1),
        .BUSY(busy1), .DATA_VALID(valid1), .DATA_OUT(dout1), .OVERRUN(ovr1)
    );

    initial begin
        forever #10 CLOCK_50MHz = ~CLOCK_50MHz;
    end

    // Converter behaviour: the n-th SCLK fall after CNVST drops presents the next bit.
    // The MSB appears at fall LAT+1, and the other falls carry random junk.
    function automatic logic [1:0] adc_bits(input logic [23:0] s, input int f);
        int idx;
        if (f >= LAT + 1 && f <= LAT + ADC_BITS) begin
            idx = ADC_BITS - 1 - (f - LAT - 1);
            return {s[ADC_BITS + idx], s[idx]};
        end
        return 2'($urandom);
    endfunction

    function automatic logic [15:0] exp_single(input logic [23:0] s);
        int c0, c1;
        c0 = (int'(s) % 4096) / 16;
        c1 = (int'(s) / 4096) / 16;
        return 16'(c1 * 256 + c0);
    endfunction

    initial begin
        forever begin
            @(posedge CLOCK_50MHz);
            #1;
            if (pc0 && !cnvst0) begin
                f0 = 0;
                if (sq0.size() > 0) cur0 = sq0.pop_front();
            end
            if (ps0 && !sclk0) begin
                f0++;
                adc_out0 = adc_bits(cur0, f0);
            end
            ps0 = sclk0; pc0 = cnvst0;
            if (pc1 && !cnvst1) begin
                f1 = 0;
                if (sq1.size() > 0) cur1 = sq1.pop_front();
            end
            if (ps1 && !sclk1) begin
                f1++;
                adc_out1 = adc_bits(cur1, f1);
            end
            ps1 = sclk1; pc1 = cnvst1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50MHz);
            #1;
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step(1);
        START = 1'b0;
    endtask

    task automatic wait_fall0(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1);
            if (cnvst0 === 1'b0) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        step(10);
        n_tests++; if (sclk0 !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk0); end
        n_tests++; if (cnvst0 !== 1'b1) begin n_fail++; $display("FAIL reset_cnvst: got %b expected 1", cnvst0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_tests++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid0); end
        n_tests++; if (dout0 !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", dout0); end
        n_tests++; if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", ovr0); end
        n_tests++; if ({cs_n0, refsel0, sd0, ub0, sel0} !== 5'b01000) begin
            n_fail++; $display("FAIL reset_const: got %b expected 01000", {cs_n0, refsel0, sd0, ub0, sel0}); end
        n_tests++; if ({cs_n1, refsel1, sd1, ub1, sel1, busy1, valid1, ovr1, cnvst1, sclk1} !== 10'b0100000010 || dout1 !== 16'h0000) begin
            n_fail++; $display("FAIL reset_avg_unit: got %b/%h expected 0100000010/0000",
                {cs_n1, refsel1, sd1, ub1, sel1, busy1, valid1, ovr1, cnvst1, sclk1}, dout1); end
        RESET_n = 1'b1;
        step(1);
    endtask

    task automatic test_single_shot();
        logic [23:0] s;
        logic [15:0] got, expv;
        int nv, low_rises;
        logic psc, pcv;
        for (int r = 0; r < 4; r++) begin
            s = (r == 0) ? 24'h3F0A5C : 24'($urandom);
            expv = (r == 0) ? 16'h3FA5 : exp_single(s);
            sq0.push_back(s);
            pulse_start();
            nv = 0; low_rises = 0; got = 16'h0000;
            psc = sclk0; pcv = cnvst0;
            for (int i = 0; i < 300; i++) begin
                step(1);
                if (!psc && sclk0 && pcv === 1'b0) low_rises++;
                if (valid0 === 1'b1) begin nv++; got = dout0; end
                psc = sclk0; pcv = cnvst0;
            end
            n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL single_valid_count[%0d]: got %0d expected 1", r, nv); end
            n_tests++; if (got !== expv) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", r, got, expv); end
            n_tests++; if (low_rises !== LAT + ADC_BITS + 1) begin
                n_fail++; $display("FAIL single_cnvst_low[%0d]: got %0d rises expected %0d", r, low_rises, LAT + ADC_BITS + 1); end
            n_tests++; if (busy0 !== 1'b0 || cnvst0 !== 1'b1 || dout0 !== expv) begin
                n_fail++; $display("FAIL single_after[%0d]: got busy=%b cnvst=%b dout=%h expected 0/1/%h", r, busy0, cnvst0, dout0, expv); end
        end
    endtask

    task automatic test_continuous();
        logic [23:0] s;
        logic [15:0] expv;
        int vt[$];
        int hi_run, nv;
        bit seen_fall, found;
        s = 24'($urandom);
        expv = exp_single(s);
        sq0.push_back(s);
        CONT = 1'b1;
        hi_run = 0; seen_fall = 1'b0;
        for (int i = 0; i < 800; i++) begin
            step(1);
            if (valid0 === 1'b1) begin
                vt.push_back(i);
                n_tests++; if (dout0 !== expv || busy0 !== 1'b0) begin
                    n_fail++; $display("FAIL cont_data: got %h busy=%b expected %h busy=0", dout0, busy0, expv); end
            end
            if (cnvst0 === 1'b1) hi_run++;
            else begin
                if (seen_fall && hi_run > 0) begin
                    n_tests++; if (hi_run !== 2 * CLK_DIV) begin
                        n_fail++; $display("FAIL cont_cnvst_gap: got %0d clocks expected %0d", hi_run, 2 * CLK_DIV); end
                end
                seen_fall = 1'b1; hi_run = 0;
            end
        end
        n_tests++; if (vt.size() < 4) begin n_fail++; $display("FAIL cont_valid_count: got %0d expected >=4", vt.size()); end
        for (int k = 1; k < vt.size(); k++) begin
            n_tests++; if (vt[k] - vt[k-1] !== PERIOD) begin
                n_fail++; $display("FAIL cont_period: got %0d expected %0d", vt[k] - vt[k-1], PERIOD); end
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (valid0 === 1'b1) found = 1'b1;
        end
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL cont_sync: got no valid expected one within 200 clocks"); end
        step($urandom_range(20, 100));
        CONT = 1'b0;
        nv = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (valid0 === 1'b1) nv++;
        end
        n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL cont_stop_count: got %0d expected 1", nv); end
        n_tests++; if (cnvst0 !== 1'b1 || busy0 !== 1'b0 || dout0 !== expv) begin
            n_fail++; $display("FAIL cont_stop_idle: got cnvst=%b busy=%b dout=%h expected 1/0/%h", cnvst0, busy0, dout0, expv); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] sa, sb;
        logic [15:0] d[$];
        int vt[$];
        bit found;
        sa = 24'($urandom); sb = 24'($urandom);
        sq0.push_back(sa); sq0.push_back(sb);
        pulse_start();
        wait_fall0(found);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL b2b_first_start: got no CNVST fall expected one"); end
        step(5 * 2 * CLK_DIV);
        pulse_start();
        n_tests++; if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b expected 0", ovr0); end
        step(30);
        pulse_start();
        step(1);
        n_tests++; if (ovr0 !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 1", ovr0); end
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (valid0 === 1'b1) begin vt.push_back(i); d.push_back(dout0); end
        end
        n_tests++; if (vt.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", vt.size()); end
        if (vt.size() == 2) begin
            n_tests++; if (vt[1] - vt[0] !== PERIOD) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", vt[1] - vt[0], PERIOD); end
            n_tests++; if (d[0] !== exp_single(sa) || d[1] !== exp_single(sb)) begin
                n_fail++; $display("FAIL b2b_data: got %h %h expected %h %h", d[0], d[1], exp_single(sa), exp_single(sb)); end
        end
        n_tests++; if (ovr0 !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun_sticky: got %b expected 1", ovr0); end
    endtask

    task automatic test_averaging();
        int c0[4], c1[4];
        int sum0, sum1, nv, nf, busy_drop;
        bit seen_fall, seen_valid;
        logic pcv;
        logic [15:0] got, expv;
        for (int r = 0; r < 2; r++) begin
            sum0 = 0; sum1 = 0;
            for (int k = 0; k < 4; k++) begin
                if (r == 0) c0[k] = (k == 0) ? 32'h7F0 : (k == 1) ? 32'h810 : 32'h800;
                else c0[k] = int'($urandom_range(0, 4095));
                c1[k] = int'($urandom_range(0, 4095));
                sum0 += c0[k]; sum1 += c1[k];
                sq1.push_back(24'(c1[k] * 4096 + c0[k]));
            end
            expv = 16'((sum1 / 64) * 256 + (sum0 / 64));
            start_a = 1'b1; step(1); start_a = 1'b0;
            nv = 0; nf = 0; busy_drop = 0; seen_fall = 1'b0; seen_valid = 1'b0;
            got = 16'h0000; pcv = cnvst1;
            for (int i = 0; i < 900; i++) begin
                step(1);
                if (pcv === 1'b1 && cnvst1 === 1'b0) begin nf++; seen_fall = 1'b1; end
                if (valid1 === 1'b1) begin nv++; got = dout1; seen_valid = 1'b1; end
                else if (seen_fall && !seen_valid && busy1 !== 1'b1) busy_drop++;
                pcv = cnvst1;
            end
            n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL avg_valid_count[%0d]: got %0d expected 1", r, nv); end
            n_tests++; if (nf !== 4) begin n_fail++; $display("FAIL avg_conversions[%0d]: got %0d expected 4", r, nf); end
            if (r == 0) begin
                n_tests++; if (got[7:0] !== 8'h80) begin n_fail++; $display("FAIL avg_ch0_fixed: got %h expected 80", got[7:0]); end
            end
            n_tests++; if (got !== expv) begin n_fail++; $display("FAIL avg_data[%0d]: got %h expected %h", r, got, expv); end
            n_tests++; if (busy_drop !== 0 || busy1 !== 1'b0) begin
                n_fail++; $display("FAIL avg_busy[%0d]: got drops=%0d end=%b expected 0/0", r, busy_drop, busy1); end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [23:0] sx, sy;
        int nv, nf;
        bit found;
        logic pcv;
        sx = 24'($urandom); sy = 24'($urandom);
        sq0.push_back(sx);
        pulse_start();
        wait_fall0(found);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_mid_start: got no CNVST fall expected one"); end
        step((LAT + 4) * 2 * CLK_DIV + $urandom_range(0, 40));
        RESET_n = 1'b0;
        step(2);
        n_tests++; if ({sclk0, cnvst0, busy0, valid0, ovr0} !== 5'b01000 || dout0 !== 16'h0000) begin
            n_fail++; $display("FAIL rst_mid_state: got %b/%h expected 01000/0000", {sclk0, cnvst0, busy0, valid0, ovr0}, dout0); end
        RESET_n = 1'b1;
        nv = 0; nf = 0; pcv = cnvst0;
        for (int i = 0; i < 250; i++) begin
            step(1);
            if (valid0 === 1'b1) nv++;
            if (pcv === 1'b1 && cnvst0 === 1'b0) nf++;
            pcv = cnvst0;
        end
        n_tests++; if (nv !== 0 || nf !== 0) begin
            n_fail++; $display("FAIL rst_mid_aborted: got valids=%0d falls=%0d expected 0/0", nv, nf); end
        sq0.push_back(sy);
        pulse_start();
        nv = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (valid0 === 1'b1) begin
                nv++;
                n_tests++; if (dout0 !== exp_single(sy)) begin
                    n_fail++; $display("FAIL rst_mid_data: got %h expected %h", dout0, exp_single(sy)); end
            end
        end
        n_tests++; if (nv !== 1 || ovr0 !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_recover: got valids=%0d overrun=%b expected 1/0", nv, ovr0); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_back_to_back();
        test_averaging();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
